// File: rtl/aes_pkg.sv
// Shared AES-128 decryption definitions: sizes, sequencer states and GF(2^8)
// helpers used by the inverse round datapath.
package aes_pkg;
    localparam int NR = 10;
    localparam int RK_IDX_W = 4;
    localparam logic [RK_IDX_W-1:0] RK_LAST = 4'd10;

    typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL, ST_DONE} fsm_t;

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant multipliers of the InvMixColumns matrix, built from x2/x4/x8 terms.
    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction
    function automatic logic [7:0] mulb(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction
    function automatic logic [7:0] muld(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction
    function automatic logic [7:0] mule(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction
endpackage

// File: rtl/inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module inverseMixColumns import aes_pkg::*; (
    input  logic [127:0] i_data,
    output logic [127:0] o_data
);
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = i_data[127-32*gi -: 8];
        assign w_a1 = i_data[119-32*gi -: 8];
        assign w_a2 = i_data[111-32*gi -: 8];
        assign w_a3 = i_data[103-32*gi -: 8];
        assign o_data[127-32*gi -: 8] = mule(w_a0) ^ mulb(w_a1) ^ muld(w_a2) ^ mul9(w_a3);
        assign o_data[119-32*gi -: 8] = mul9(w_a0) ^ mule(w_a1) ^ mulb(w_a2) ^ muld(w_a3);
        assign o_data[111-32*gi -: 8] = muld(w_a0) ^ mul9(w_a1) ^ mule(w_a2) ^ mulb(w_a3);
        assign o_data[103-32*gi -: 8] = mulb(w_a0) ^ muld(w_a1) ^ mul9(w_a2) ^ mule(w_a3);
    end
endmodule

module inv_round import aes_pkg::*; (
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] next_state
);
    logic [127:0] w_sub;
    logic [127:0] w_ark;
    logic [127:0] w_mix;

    // Byte gi sits at row gi%4, column gi/4; row r is rotated right by r columns.
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int SRC = 4 * (((gi / 4) + 4 - (gi % 4)) % 4) + (gi % 4);
        assign w_sub[127-8*gi -: 8] = inv_sbox(state[127-8*SRC -: 8]);
    end

    assign w_ark = w_sub ^ rk;

    inverseMixColumns u_imc (
        .i_data (w_ark),
        .o_data (w_mix)
    );

    assign next_state = last ? w_ark : w_mix;
endmodule

// File: rtl/inv_cipher_ctrl.sv
// Iterative AES-128 decryption sequencer: one inverse round per clock, round keys
// fetched by index from an external key store, valid/ready on both sides.
module inv_cipher_ctrl import aes_pkg::*; #(
    parameter int NR = aes_pkg::NR
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        rk,
    output logic                busy
);
    fsm_t                r_fsm;
    logic [127:0]        r_state;
    logic [RK_IDX_W-1:0] r_cnt;
    logic [RK_IDX_W-1:0] r_rk_idx;
    logic                r_out_valid;
    logic                r_busy;
    logic [127:0]        w_round;
    logic                w_last;

    assign w_last = (r_fsm == ST_FINAL);

    inv_round u_round (
        .state      (r_state),
        .rk         (rk),
        .last       (w_last),
        .next_state (w_round)
    );

    // A finished block can hand over its output and take the next one in the same cycle.
    assign in_ready  = (r_fsm == ST_IDLE) || ((r_fsm == ST_DONE) && out_ready);
    assign out_valid = r_out_valid;
    assign out_data  = r_state;
    assign rk_idx    = r_rk_idx;
    assign busy      = r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm       <= ST_IDLE;
            r_state     <= '0;
            r_cnt       <= '0;
            r_rk_idx    <= RK_LAST;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE, ST_DONE: begin
                    if (in_valid && in_ready) begin
                        r_state     <= in_data ^ rk;
                        r_cnt       <= RK_IDX_W'(NR - 1);
                        r_rk_idx    <= RK_IDX_W'(NR - 1);
                        r_fsm       <= ST_ROUND;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b1;
                    end else if ((r_fsm == ST_DONE) && out_ready) begin
                        r_fsm       <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_ROUND: begin
                    r_state <= w_round;
                    if (r_cnt == 4'd1) begin
                        r_fsm    <= ST_FINAL;
                        r_rk_idx <= '0;
                    end else begin
                        r_cnt    <= r_cnt - 1'b1;
                        r_rk_idx <= r_cnt - 1'b1;
                    end
                end
                ST_FINAL: begin
                    r_state     <= w_round;
                    r_fsm       <= ST_DONE;
                    r_rk_idx    <= RK_LAST;
                    r_out_valid <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// Directed and randomised checks of inv_cipher_ctrl against known AES-128 vectors
// and an independent forward-cipher model used for round-trip regression.
module tb_inv_cipher_ctrl;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   sbox_tab [256];
    logic [127:0] rk_mem   [11];

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_E1  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] PT_E1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT_E2  = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] PT_E2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    always #5 clk = ~clk;

    assign rk = (rk_idx <= 4'd10) ? rk_mem[rk_idx] : 128'd0;

    inv_cipher_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rk_idx    (rk_idx),
        .rk        (rk),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Forward S-box from first principles: multiplicative inverse then affine map.
    function automatic logic [7:0] calc_sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]],
                       sbox_tab[tmp[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 11; k++) rk_mem[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [127:0] s;
        logic [127:0] t;
        logic [7:0]   a0, a1, a2, a3;
        int           src;
        s = pt ^ rk_mem[0];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int k = 0; k < 16; k++) begin
                src = 4 * (((k / 4) + (k % 4)) % 4) + (k % 4);
                t[127-8*k -: 8] = sbox_tab[s[127-8*src -: 8]];
            end
            s = t;
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[127-32*c -: 8];
                    a1 = t[119-32*c -: 8];
                    a2 = t[111-32*c -: 8];
                    a3 = t[103-32*c -: 8];
                    s[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            s = s ^ rk_mem[rnd];
        end
        return s;
    endfunction

    // One block from IDLE to IDLE, optionally stalling the output or poking in_valid mid-run.
    task automatic decrypt(input string tag, input logic [127:0] ct, input logic [127:0] pt,
                           input int stall, input bit poke, input bit chk_seq);
        logic [47:0] seq;
        int          lat;
        int          bad;
        in_data   = ct;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        #1;
        check_eq({tag, " in_ready idle"}, 128'(in_ready), 128'd1);
        seq = {44'd0, rk_idx};
        tick();
        in_valid = 1'b0;
        in_data  = {4{32'hdeadbeef}};
        check_eq({tag, " busy"}, 128'(busy), 128'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            seq = {seq[43:0], rk_idx};
            in_valid = 1'b0;
            if (poke && lat == 4) begin
                in_valid = 1'b1;
                check_eq({tag, " in_ready in round"}, 128'(in_ready), 128'd0);
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        seq = {seq[43:0], rk_idx};
        check_eq({tag, " latency"}, 128'(lat), 128'd10);
        check_eq({tag, " data"}, out_data, pt);
        if (chk_seq) check_eq({tag, " rk_idx seq"}, 128'(seq), 128'h_a9876543210a);
        if (stall > 0) begin
            bad = 0;
            for (int i = 0; i < stall; i++) begin
                in_valid = 1'b1;
                #1;
                if (!out_valid || out_data !== pt || in_ready || rk_idx != 4'd10) bad++;
                tick();
            end
            in_valid = 1'b0;
            check_eq({tag, " stall violations"}, 128'(bad), 128'd0);
            out_ready = 1'b1;
        end
        tick();
        check_eq({tag, " out_valid after xfer"}, 128'(out_valid), 128'd0);
        check_eq({tag, " in_ready after xfer"}, 128'(in_ready), 128'd1);
        $display("[TB] %s ct=%h pt=%h lat=%0d", tag, ct, out_data, lat);
    endtask

    initial begin
        int lat1;
        int lat2;
        int cyc;
        bit got;
        logic [127:0] key, pt, ct, data;

        for (int i = 0; i < 256; i++) sbox_tab[i] = calc_sbox(8'(i));
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        expand(KEY_C1);
        check_eq("rk10 model", rk_mem[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        repeat (2) tick();
        rst_n = 1'b1;
        check_eq("reset out_valid", 128'(out_valid), 128'd0);
        check_eq("reset out_data", out_data, 128'd0);
        check_eq("reset busy", 128'(busy), 128'd0);
        check_eq("reset in_ready", 128'(in_ready), 128'd1);
        check_eq("reset rk_idx", 128'(rk_idx), 128'd10);

        decrypt("c1", CT_C1, PT_C1, 0, 1'b0, 1'b1);

        expand(KEY_B);
        decrypt("backpressure", CT_B, PT_B, 20, 1'b0, 1'b0);
        decrypt("ignore", CT_E1, PT_E1, 0, 1'b1, 1'b0);

        // Back-to-back: second accept rides on the first output transfer.
        in_valid = 1'b1; in_data = CT_E1; out_ready = 1'b1;
        tick();
        in_data = CT_E2;
        lat1 = 0;
        while (!out_valid && lat1 < 40) begin tick(); lat1++; end
        check_eq("b2b first data", out_data, PT_E1);
        check_eq("b2b in_ready in done", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        check_eq("b2b accepted busy", 128'(busy), 128'd1);
        check_eq("b2b out_valid drop", 128'(out_valid), 128'd0);
        lat2 = 1;
        while (!out_valid && lat2 < 40) begin tick(); lat2++; end
        check_eq("b2b output spacing", 128'(lat2), 128'd11);
        check_eq("b2b second data", out_data, PT_E2);
        $display("[TB] b2b ct=%h pt=%h spacing=%0d", CT_E2, out_data, lat2);
        tick();
        check_eq("b2b idle", 128'(out_valid), 128'd0);

        // Reset while the block is around round 5.
        expand(KEY_C1);
        in_valid = 1'b1; in_data = CT_C1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("midrst out_valid", 128'(out_valid), 128'd0);
        check_eq("midrst busy", 128'(busy), 128'd0);
        check_eq("midrst in_ready", 128'(in_ready), 128'd1);
        check_eq("midrst rk_idx", 128'(rk_idx), 128'd10);
        check_eq("midrst out_data", out_data, 128'd0);
        $display("[TB] reset mid-round applied");
        decrypt("after reset", CT_C1, PT_C1, 0, 1'b0, 1'b1);

        // Round-trip regression with random keys and random consumer stalls.
        for (int b = 0; b < 24; b++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            expand(key);
            ct = aes_enc(pt);
            in_valid = 1'b0; out_ready = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            in_valid = 1'b1; in_data = ct;
            tick();
            in_valid = 1'b0;
            cyc = 0; got = 1'b0; data = '0;
            while (!got && cyc < 100) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    data = out_data;
                    got  = 1'b1;
                end
                tick();
                cyc++;
            end
            out_ready = 1'b0;
            check_eq($sformatf("rand%0d transfer", b), 128'(got), 128'd1);
            check_eq($sformatf("rand%0d data", b), data, pt);
            check_eq($sformatf("rand%0d no dup", b), 128'(out_valid), 128'd0);
            $display("[TB] rand%0d key=%h ct=%h pt=%h", b, key, ct, data);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
